// File: rtl/stage2_window_gen_pkg.sv
// Shared sizes and types for the stage-2 5x5 sliding-window generator.
package stage2_window_gen_pkg;

  localparam int unsigned KX           = 5;
  localparam int unsigned KY           = 5;
  localparam int unsigned ST2_Conv_IBW = 20;
  localparam int unsigned ST2_IW       = 12;
  localparam int unsigned ST2_IH       = 12;
  localparam int unsigned WIN_W        = KX * KY * ST2_Conv_IBW;

  typedef logic [ST2_Conv_IBW-1:0] pix_t;

endpackage

// File: rtl/stage2_line_buffer.sv
// Enabled shift delay line: dout is the sample written DEPTH enabled cycles earlier.
module stage2_line_buffer #(
  parameter int unsigned DEPTH = 12,
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Data path deliberately unreset; contents are rewritten before use.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/stage2_window_gen.sv
// Streaming 5x5 window generator for the stage-2 CNN kernels.
// Optional debug ports enabled by defining STAGE2_WIN_DBG_EN.
module stage2_window_gen
  import stage2_window_gen_pkg::*;
#(
  parameter int unsigned IW = ST2_IW,
  parameter int unsigned IH = ST2_IH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_in_valid,
  input  logic [ST2_Conv_IBW-1:0] i_in_pixel,
  output logic                    o_ot_valid,
  output logic [WIN_W-1:0]        o_ot_fmap,
  output logic                    o_frame_done
`ifdef STAGE2_WIN_DBG_EN
  ,
  output logic [$clog2(IH)-1:0]   o_dbg_row,
  output logic [$clog2(IW)-1:0]   o_dbg_col,
  output logic                    o_dbg_err
`endif
);

  localparam int unsigned CW = $clog2(IW);
  localparam int unsigned RW = $clog2(IH);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  pix_t          win    [KY][KX];
  pix_t          lb_tap [KY];
  logic          win_done_c;
  logic          last_c;

  assign win_done_c = (row >= RW'(KY - 1)) && (col >= CW'(KX - 1));
  assign last_c     = (row == RW'(IH - 1)) && (col == CW'(IW - 1));

  // Tap k is the pixel k rows above the current position.
  assign lb_tap[0] = i_in_pixel;

  for (genvar k = 1; k < int'(KY); k++) begin : g_line
    stage2_line_buffer #(
      .DEPTH (IW),
      .WIDTH (ST2_Conv_IBW)
    ) u_line (
      .clk  (clk),
      .en   (i_in_valid),
      .din  (lb_tap[k-1]),
      .dout (lb_tap[k])
    );
  end

  for (genvar y = 0; y < int'(KY); y++) begin : g_pack_y
    for (genvar x = 0; x < int'(KX); x++) begin : g_pack_x
      assign o_ot_fmap[(y*KX+x)*ST2_Conv_IBW +: ST2_Conv_IBW] = win[y][x];
    end
  end

  // Position counters, window shift register and output strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row          <= '0;
      col          <= '0;
      o_ot_valid   <= 1'b0;
      o_frame_done <= 1'b0;
      for (int y = 0; y < int'(KY); y++) begin
        for (int x = 0; x < int'(KX); x++) begin
          win[y][x] <= '0;
        end
      end
    end else begin
      o_ot_valid   <= i_in_valid && win_done_c;
      o_frame_done <= i_in_valid && last_c;
      if (i_in_valid) begin
        for (int y = 0; y < int'(KY); y++) begin
          for (int x = 0; x < int'(KX) - 1; x++) begin
            win[y][x] <= win[y][x+1];
          end
          win[y][KX-1] <= lb_tap[int'(KY) - 1 - y];
        end
        if (col == CW'(IW - 1)) begin
          col <= '0;
          row <= (row == RW'(IH - 1)) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

`ifdef STAGE2_WIN_DBG_EN
  // Output position of the window being flagged.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_dbg_row <= '0;
      o_dbg_col <= '0;
    end else if (i_in_valid && win_done_c) begin
      o_dbg_row <= row - RW'(KY - 1);
      o_dbg_col <= col - CW'(KX - 1);
    end
  end

`ifdef SYNTHESIS
  assign o_dbg_err = 1'b0;
`else
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_dbg_err <= 1'b0;
    end else if (i_in_valid && $isunknown(i_in_pixel)) begin
      o_dbg_err <= 1'b1;
    end
  end
`endif
`endif

endmodule

// File: tb/tb_stage2_window_gen.sv
// Randomized self-checking bench for stage2_window_gen against a direct frame-indexing model.
module tb_stage2_window_gen;

  localparam int IW = 12;
  localparam int IH = 12;
  localparam int KX = 5;
  localparam int KY = 5;
  localparam int BW = 20;
  localparam int FW = KX * KY * BW;
  localparam int NWIN = (IW - KX + 1) * (IH - KY + 1);

  typedef struct packed {
    logic [FW-1:0] fmap;
    logic          done;
    logic [31:0]   stamp;
  } win_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_in_valid = 1'b0;
  logic [BW-1:0] i_in_pixel = '0;
  logic          o_ot_valid;
  logic [FW-1:0] o_ot_fmap;
  logic          o_frame_done;
`ifdef STAGE2_WIN_DBG_EN
  logic [3:0]    o_dbg_row;
  logic [3:0]    o_dbg_col;
  logic          o_dbg_err;
`endif

  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            stray_done = 0;
  logic [BW-1:0] frame [IH][IW];
  int            stamp_of [IH][IW];
  win_t          exp_q[$];
  win_t          obs_q[$];
  win_t          ref_q[$];

  stage2_window_gen dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_in_valid   (i_in_valid),
    .i_in_pixel   (i_in_pixel),
    .o_ot_valid   (o_ot_valid),
    .o_ot_fmap    (o_ot_fmap),
    .o_frame_done (o_frame_done)
`ifdef STAGE2_WIN_DBG_EN
    ,
    .o_dbg_row    (o_dbg_row),
    .o_dbg_col    (o_dbg_col),
    .o_dbg_err    (o_dbg_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (o_ot_valid) obs_q.push_back('{fmap: o_ot_fmap, done: o_frame_done, stamp: 32'(cyc)});
      else if (o_frame_done) stray_done++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic clear_queues();
    exp_q.delete();
    obs_q.delete();
    stray_done = 0;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) frame[r][c] = BW'(r * IW + c);
  endtask

  // Drives one frame and records the windows it must produce.
  task automatic drive_frame(input bit gaps, input bit idle_after);
    win_t w;
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        if (gaps) begin
          while ($urandom_range(0, 2) != 0) begin
            @(negedge clk);
            i_in_valid = 1'b0;
            i_in_pixel = BW'($urandom);
          end
        end
        @(negedge clk);
        i_in_valid = 1'b1;
        i_in_pixel = frame[r][c];
        stamp_of[r][c] = cyc + 1;
        if (r >= KY - 1 && c >= KX - 1) begin
          w.fmap = '0;
          for (int y = 0; y < KY; y++)
            for (int x = 0; x < KX; x++)
              w.fmap[(y*KX+x)*BW +: BW] = frame[r-KY+1+y][c-KX+1+x];
          w.done = (r == IH - 1) && (c == IW - 1);
          w.stamp = 32'(cyc + 1);
          exp_q.push_back(w);
        end
      end
    end
    if (idle_after) begin
      @(negedge clk);
      i_in_valid = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    i_in_valid = 1'b1;
    i_in_pixel = BW'($urandom);
    repeat (3) @(negedge clk);
    tests++;
    if (o_ot_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid: got %b expected 0", o_ot_valid);
    end
    tests++;
    if (o_frame_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_done: got %b expected 0", o_frame_done);
    end
    tests++;
    if (o_ot_fmap !== '0) begin
      fails++;
      $display("FAIL reset_fmap: got %h expected 0", o_ot_fmap);
    end
    reset_n = 1'b1;
    i_in_valid = 1'b0;
    @(negedge clk);
    clear_queues();
  endtask

  task automatic test_ramp();
    logic [FW-1:0] f;
    clear_queues();
    fill_ramp();
    drive_frame(1'b0, 1'b1);
    tests++;
    if (obs_q.size() != NWIN) begin
      fails++;
      $display("FAIL ramp_count: got %0d expected %0d", obs_q.size(), NWIN);
    end
    if (obs_q.size() > 0) begin
      f = obs_q[0].fmap;
      tests++;
      if (f[0 +: BW] !== 20'd0 || f[4*BW +: BW] !== 20'd4 || f[20*BW +: BW] !== 20'd48 ||
          f[24*BW +: BW] !== 20'd52) begin
        fails++;
        $display("FAIL ramp_first_corners: got %0d %0d %0d %0d expected 0 4 48 52",
                 f[0 +: BW], f[4*BW +: BW], f[20*BW +: BW], f[24*BW +: BW]);
      end
      tests++;
      if (obs_q[0].stamp !== 32'(stamp_of[4][4] )) begin
        fails++;
        $display("FAIL ramp_first_latency: got cycle %0d expected %0d", obs_q[0].stamp, stamp_of[4][4]);
      end
      f = obs_q[obs_q.size()-1].fmap;
      tests++;
      if (f[24*BW +: BW] !== 20'd143 || obs_q[obs_q.size()-1].done !== 1'b1) begin
        fails++;
        $display("FAIL ramp_last: got elem=%0d done=%b expected elem=143 done=1",
                 f[24*BW +: BW], obs_q[obs_q.size()-1].done);
      end
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL ramp_win%0d: got %h/%b/%0d expected %h/%b/%0d", i, obs_q[i].fmap, obs_q[i].done,
                 obs_q[i].stamp, exp_q[i].fmap, exp_q[i].done, exp_q[i].stamp);
      end
    end
    tests++;
    if (stray_done != 0) begin
      fails++;
      $display("FAIL ramp_stray_done: got %0d expected 0", stray_done);
    end
    ref_q = obs_q;
  endtask

  task automatic test_gaps();
    clear_queues();
    fill_ramp();
    drive_frame(1'b1, 1'b1);
    tests++;
    if (obs_q.size() != NWIN) begin
      fails++;
      $display("FAIL gaps_count: got %0d expected %0d", obs_q.size(), NWIN);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL gaps_win%0d: got %h/%b/%0d expected %h/%b/%0d", i, obs_q[i].fmap, obs_q[i].done,
                 obs_q[i].stamp, exp_q[i].fmap, exp_q[i].done, exp_q[i].stamp);
      end
    end
    for (int i = 0; i < ref_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i].fmap !== ref_q[i].fmap) begin
        fails++;
        $display("FAIL gaps_vs_ramp%0d: got %h expected %h", i, obs_q[i].fmap, ref_q[i].fmap);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    clear_queues();
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) frame[r][c] = BW'($urandom);
    drive_frame(1'b0, 1'b0);
    drive_frame(1'b0, 1'b1);
    tests++;
    if (obs_q.size() != 2 * NWIN) begin
      fails++;
      $display("FAIL b2b_count: got %0d expected %0d", obs_q.size(), 2 * NWIN);
    end
    dones = 0;
    foreach (obs_q[i]) if (obs_q[i].done) dones++;
    tests++;
    if (dones != 2 || stray_done != 0) begin
      fails++;
      $display("FAIL b2b_done_pulses: got %0d (stray %0d) expected 2", dones, stray_done);
    end
    if (obs_q.size() > NWIN) begin
      tests++;
      if (obs_q[NWIN].fmap !== obs_q[0].fmap || obs_q[0].fmap !== exp_q[0].fmap) begin
        fails++;
        $display("FAIL b2b_first_win: got %h expected %h", obs_q[NWIN].fmap, exp_q[0].fmap);
      end
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL b2b_win%0d: got %h/%b/%0d expected %h/%b/%0d", i, obs_q[i].fmap, obs_q[i].done,
                 obs_q[i].stamp, exp_q[i].fmap, exp_q[i].done, exp_q[i].stamp);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) frame[r][c] = BW'($urandom);
    for (int p = 0; p < 60; p++) begin
      @(negedge clk);
      i_in_valid = 1'b1;
      i_in_pixel = frame[p / IW][p % IW];
    end
    @(negedge clk);
    reset_n = 1'b0;
    i_in_pixel = BW'($urandom);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    i_in_valid = 1'b0;
    clear_queues();
    fill_ramp();
    drive_frame(1'b1, 1'b1);
    tests++;
    if (obs_q.size() != NWIN) begin
      fails++;
      $display("FAIL rstmid_count: got %0d expected %0d", obs_q.size(), NWIN);
    end
    if (obs_q.size() > 0) begin
      tests++;
      if (obs_q[0].stamp !== 32'(stamp_of[4][4])) begin
        fails++;
        $display("FAIL rstmid_first_latency: got cycle %0d expected %0d", obs_q[0].stamp, stamp_of[4][4]);
      end
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL rstmid_win%0d: got %h/%b/%0d expected %h/%b/%0d", i, obs_q[i].fmap, obs_q[i].done,
                 obs_q[i].stamp, exp_q[i].fmap, exp_q[i].done, exp_q[i].stamp);
      end
    end
  endtask

  task automatic test_sign();
    logic [FW-1:0] f;
    clear_queues();
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) frame[r][c] = 20'hFFFFF;
    frame[6][7] = 20'h80000;
    drive_frame(1'b1, 1'b1);
    if (obs_q.size() == NWIN) begin
      f = obs_q[2 * (IW - KX + 1) + 3].fmap;
      tests++;
      if (f[24*BW +: BW] !== 20'h80000) begin
        fails++;
        $display("FAIL sign_marker: got %h expected 80000", f[24*BW +: BW]);
      end
      f = obs_q[0].fmap;
      tests++;
      if (f !== {(KX*KY){20'hFFFFF}}) begin
        fails++;
        $display("FAIL sign_all_ones: got %h expected all FFFFF", f);
      end
    end else begin
      tests++;
      fails++;
      $display("FAIL sign_count: got %0d expected %0d", obs_q.size(), NWIN);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL sign_win%0d: got %h/%b/%0d expected %h/%b/%0d", i, obs_q[i].fmap, obs_q[i].done,
                 obs_q[i].stamp, exp_q[i].fmap, exp_q[i].done, exp_q[i].stamp);
      end
    end
`ifdef STAGE2_WIN_DBG_EN
    tests++;
    if (o_dbg_err !== 1'b0) begin
      fails++;
      $display("FAIL dbg_err: got %b expected 0", o_dbg_err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_gaps();
    test_back_to_back();
    test_reset_mid_frame();
    test_sign();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
